// File: rtl/parity_frame_pkg.sv
// parity_frame_pkg
// Shared types and constants for the parity frame serializer.
//   frameState_t : serializer FSM state encoding
//   FRAME_BITS   : serial bits per frame (start, 4 data, parity, stop)
//   DATA_BITS    : payload bits per frame
//   IDLE_LEVEL   : serial line level between frames
package parity_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frameState_t;

  localparam int   FRAME_BITS = 7;
  localparam int   DATA_BITS  = 4;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/parity_frame_bit_timer.sv
// parity_frame_bit_timer
// Counts clock cycles within one serial bit period and flags the last one.
// Ports:
//   InClk   : rising-edge clock
//   InRstN  : asynchronous active-low reset
//   InClear : restart the bit period (a new frame was accepted)
//   OutTick : high during the final cycle of the current bit period
// Parameter CLKS_PER_BIT: cycles per serial bit, 1..255.
module parity_frame_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic InClk,
  input  logic InRstN,
  input  logic InClear,
  output logic OutTick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      count <= '0;
    end else if (InClear || OutTick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With CLKS_PER_BIT=1 the counter stays at 0 and every cycle is a tick.
  assign OutTick = (count == LAST_COUNT);

endmodule

// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer
// Accepts a nibble plus its even-parity bit and transmits it as a 7-bit
// serial frame: start(0), InA, InB, InC, InD, parity, stop(1).
// Ports:
//   InClk, InRstN      : clock, asynchronous active-low reset
//   InA..InD           : data bits, InA transmitted first
//   InP                : parity bit from the upstream generator
//   InValid / OutReady : word handshake, accepted when both are high
//   OutTx              : registered serial line, idle high
//   OutBusy            : a frame is in progress
//   OutDone            : one-cycle pulse in the last cycle of the stop bit
//   OutParityErr       : upstream parity was wrong (only with PARITY_CHECK_EN)
// Parameter CLKS_PER_BIT: cycles per serial bit, 1..255.
// Build option: define PARITY_CHECK_EN to add the parity check and its port.
module parity_frame_serializer
  import parity_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic InClk,
  input  logic InRstN,
  input  logic InA,
  input  logic InB,
  input  logic InC,
  input  logic InD,
  input  logic InP,
  input  logic InValid,
  output logic OutReady,
  output logic OutTx,
  output logic OutBusy,
  output logic OutDone
`ifdef PARITY_CHECK_EN
  ,
  output logic OutParityErr
`endif
);

  frameState_t          state, stateNext;
  logic [1:0]           bitIdx, bitIdxNext;
  logic [DATA_BITS-1:0] dataReg, dataNext;
  logic                 parityReg, parityNext;
  logic                 txReg, txNext;
  logic                 tick;
  logic                 accept;

  parity_frame_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBitTimer (
    .InClk  (InClk),
    .InRstN (InRstN),
    .InClear(accept),
    .OutTick(tick)
  );

  // Ready in the last stop cycle too, so back-to-back frames leave no gap.
  assign OutReady = (state == IDLE) || ((state == STOP) && tick);
  assign accept   = InValid && OutReady;
  assign OutBusy  = (state != IDLE);
  assign OutDone  = (state == STOP) && tick;
  assign OutTx    = txReg;

  always_comb begin
    stateNext  = state;
    bitIdxNext = bitIdx;
    dataNext   = dataReg;
    parityNext = parityReg;
    txNext     = IDLE_LEVEL;

    if (accept) begin
      dataNext   = {InD, InC, InB, InA};
      parityNext = InP;
    end

    case (state)
      IDLE:    if (accept) stateNext = START;
      START:   if (tick) begin
                 stateNext  = DATA;
                 bitIdxNext = '0;
               end
      DATA:    if (tick) begin
                 if (bitIdx == 2'(DATA_BITS - 1)) stateNext = PARITY;
                 else bitIdxNext = bitIdx + 1'b1;
               end
      PARITY:  if (tick) stateNext = STOP;
      STOP:    if (tick) stateNext = accept ? START : IDLE;
      default: stateNext = IDLE;
    endcase

    // The line level is decided from the next state so OutTx can be a flop
    // and the start bit still appears the cycle after the accept edge.
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = dataNext[bitIdxNext];
      PARITY:  txNext = parityNext;
      default: txNext = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      state  <= IDLE;
      bitIdx <= '0;
      txReg  <= IDLE_LEVEL;
    end else begin
      state  <= stateNext;
      bitIdx <= bitIdxNext;
      txReg  <= txNext;
    end
  end

  // Payload holding registers carry no reset; they are only read after an accept.
  always_ff @(posedge InClk) begin
    dataReg   <= dataNext;
    parityReg <= parityNext;
  end

`ifdef PARITY_CHECK_EN
  // Even parity over data plus parity bit must be zero; flag holds until next accept.
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      OutParityErr <= 1'b0;
    end else if (accept) begin
      OutParityErr <= ^{InA, InB, InC, InD, InP};
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Testbench for parity_frame_serializer: one instance with CLKS_PER_BIT=4 and
// one with CLKS_PER_BIT=1. A reference model pushes the expected per-cycle
// line/status values onto a scoreboard queue at each accept; a monitor pops
// and compares one entry every cycle, expecting idle values when empty.
module tb_parity_frame_serializer;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
    logic ready;
  } ent_t;

  logic InClk = 1'b0;
  logic InRstN;
  logic valid[2], a[2], b[2], c[2], d[2], p[2];
  logic tx[2], busy[2], done[2], ready[2];
`ifdef PARITY_CHECK_EN
  logic perr[2];
  logic expPerr[2];
`endif

  ent_t sb[2][$];
  int   accCnt[2];
  int   testCnt = 0;
  int   failCnt = 0;

  always #5 InClk = ~InClk;

  parity_frame_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .InClk(InClk), .InRstN(InRstN),
    .InA(a[0]), .InB(b[0]), .InC(c[0]), .InD(d[0]), .InP(p[0]),
    .InValid(valid[0]), .OutReady(ready[0]), .OutTx(tx[0]),
    .OutBusy(busy[0]), .OutDone(done[0])
`ifdef PARITY_CHECK_EN
    , .OutParityErr(perr[0])
`endif
  );

  parity_frame_serializer #(.CLKS_PER_BIT(1)) dut1 (
    .InClk(InClk), .InRstN(InRstN),
    .InA(a[1]), .InB(b[1]), .InC(c[1]), .InD(d[1]), .InP(p[1]),
    .InValid(valid[1]), .OutReady(ready[1]), .OutTx(tx[1]),
    .OutBusy(busy[1]), .OutDone(done[1])
`ifdef PARITY_CHECK_EN
    , .OutParityErr(perr[1])
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Reference model: an accept happens when the line is free in the cycle
  // just ended, i.e. no expected entries remain queued.
  always @(posedge InClk) begin
    for (int i = 0; i < 2; i++) begin
      if (InRstN && valid[i] && sb[i].size() == 0) begin
        logic fb[7];
        ent_t e;
        fb[0] = 1'b0; fb[1] = a[i]; fb[2] = b[i]; fb[3] = c[i];
        fb[4] = d[i]; fb[5] = p[i]; fb[6] = 1'b1;
        for (int k = 0; k < 7; k++) begin
          for (int n = 0; n < cpb(i); n++) begin
            e.tx    = fb[k];
            e.busy  = 1'b1;
            e.done  = (k == 6) && (n == cpb(i) - 1);
            e.ready = e.done;
            sb[i].push_back(e);
          end
        end
`ifdef PARITY_CHECK_EN
        expPerr[i] = a[i] ^ b[i] ^ c[i] ^ d[i] ^ p[i];
`endif
        accCnt[i]++;
      end
    end
  end

  always @(negedge InClk) begin
    for (int i = 0; i < 2; i++) begin
      ent_t e;
      if (sb[i].size() > 0) e = sb[i].pop_front();
      else e = '{tx: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};
      checkVal($sformatf("tx[cpb%0d]", cpb(i)), tx[i], e.tx);
      checkVal($sformatf("busy[cpb%0d]", cpb(i)), busy[i], e.busy);
      checkVal($sformatf("done[cpb%0d]", cpb(i)), done[i], e.done);
      checkVal($sformatf("ready[cpb%0d]", cpb(i)), ready[i], e.ready);
`ifdef PARITY_CHECK_EN
      checkVal($sformatf("parityErr[cpb%0d]", cpb(i)), perr[i], expPerr[i]);
`endif
    end
  end

  task automatic clearModel();
    for (int i = 0; i < 2; i++) begin
      sb[i].delete();
`ifdef PARITY_CHECK_EN
      expPerr[i] = 1'b0;
`endif
    end
  endtask

  // Present a word, wait (bounded) for the model to see it accepted, then
  // scramble the inputs to show they no longer matter.
  task automatic sendWord(input int i, input logic wa, input logic wb, input logic wc,
                          input logic wd, input logic wp, input logic holdValid);
    int start;
    int n;
    a[i] = wa; b[i] = wb; c[i] = wc; d[i] = wd; p[i] = wp;
    valid[i] = 1'b1;
    start = accCnt[i];
    n = 0;
    while (accCnt[i] == start && n < 200) begin
      @(negedge InClk);
      n++;
    end
    checkVal("acceptTimeout", (accCnt[i] != start), 1);
    if (!holdValid) valid[i] = 1'b0;
    a[i] = 1'($urandom); b[i] = 1'($urandom); c[i] = 1'($urandom);
    d[i] = 1'($urandom); p[i] = 1'($urandom);
  endtask

  task automatic waitIdle(input int i);
    int n;
    n = 0;
    while (sb[i].size() != 0 && n < 1000) begin
      @(negedge InClk);
      n++;
    end
    checkVal("drainTimeout", (sb[i].size() == 0), 1);
    repeat (3) @(negedge InClk);
  endtask

  initial begin
    InRstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; a[i] = 1'b0; b[i] = 1'b0; c[i] = 1'b0; d[i] = 1'b0; p[i] = 1'b0;
      accCnt[i] = 0;
    end
    clearModel();
    repeat (3) @(negedge InClk);
    checkVal("resetTx", tx[0], 1);
    checkVal("resetReady", ready[0], 1);
    checkVal("resetBusy", busy[0], 0);
    checkVal("resetDone", done[0], 0);
    InRstN = 1'b1;
    repeat (2) @(negedge InClk);

    // Single frame, 1,0,1,1 with parity 1
    sendWord(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    waitIdle(0);

    // Back-to-back with InValid held high
    sendWord(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sendWord(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    waitIdle(0);

    // Reset during the DATA bit-index-2 period (cycles 12..15 after accept)
    sendWord(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (13) @(negedge InClk);
    #2;
    InRstN = 1'b0;
    clearModel();
    #1;
    checkVal("midResetTx", tx[0], 1);
    checkVal("midResetBusy", busy[0], 0);
    checkVal("midResetReady", ready[0], 1);
    @(negedge InClk);
    InRstN = 1'b1;
    @(negedge InClk);
    sendWord(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitIdle(0);

    // One cycle per bit: single frame, then back-to-back
    sendWord(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitIdle(1);
    sendWord(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    sendWord(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    waitIdle(1);

    // Wrong upstream parity, then a correct word
    sendWord(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitIdle(0);
    sendWord(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle(0);
    sendWord(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitIdle(1);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
